// File: rtl/psm_wmask_scheduler.sv
// Write-mask / FIFO-pop / address sequencer for the PSM write-data manager.
// Optional stall counter (o_stall_cnt) is built when PSM_WSCHED_PERF_EN is defined.
module psm_wmask_scheduler #(
  parameter int Y       = 3,
  parameter int SRAMC_N = 2,
  parameter int WOFS_W  = 3,
  parameter int CNT_W   = 16,
  parameter int ADDR_W  = 10
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_start,
  input  logic [CNT_W-1:0]    i_n_elems,
  input  logic [WOFS_W-1:0]   i_wofs_init,
  input  logic [ADDR_W-1:0]   i_base_addr,
  input  logic                i_feeder_en,
  input  logic                i_fifo_empty,
  output logic [0:SRAMC_N-1]  o_mask,
  output logic                o_fifo_pop,
  output logic                o_clearbuff,
  output logic [ADDR_W-1:0]   o_sram_addr,
  output logic                o_busy,
  output logic                o_done
`ifdef PSM_WSCHED_PERF_EN
  ,
  output logic [31:0]         o_stall_cnt
`endif
);

  localparam int USED_W = $clog2(Y + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state;
  logic [CNT_W-1:0]  remaining;
  logic [WOFS_W-1:0] lane;
  logic [USED_W-1:0] used;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_s1;
  logic              drain_cnt;

  logic              issue;
  logic              start_ok;
  logic [CNT_W-1:0]  room_y;
  logic [CNT_W-1:0]  room_w;
  logic [CNT_W-1:0]  n_take;
  logic [CNT_W-1:0]  lane_end;
  logic [CNT_W-1:0]  used_next;
  logic              last_beat;
  logic              lane_wrap;

  assign issue    = (state == S_ISSUE) && i_feeder_en && !i_fifo_empty;
  assign start_ok = (state == S_IDLE) && i_start;
  assign o_busy   = (state != S_IDLE);

  // Beat size is bounded by what is left in the FIFO word, the SRAM word and the transfer.
  always_comb begin
    room_y = CNT_W'(Y) - CNT_W'(used);
    room_w = CNT_W'(SRAMC_N) - CNT_W'(lane);
    n_take = room_y;
    if (room_w < n_take)    n_take = room_w;
    if (remaining < n_take) n_take = remaining;
    lane_end  = CNT_W'(lane) + n_take;
    used_next = CNT_W'(used) + n_take;
    last_beat = (remaining == n_take);
    lane_wrap = (lane_end == CNT_W'(SRAMC_N));
  end

  // NOTE: every variable driven here gets a default first, so no latch can be inferred.
  always_comb begin
    o_mask = '0;
    for (int i = 0; i < SRAMC_N; i++) begin
      o_mask[i] = issue && (CNT_W'(i) >= CNT_W'(lane)) && (CNT_W'(i) < lane_end);
    end
    o_fifo_pop = issue && ((used_next == CNT_W'(Y)) || last_beat);
  end

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= S_IDLE;
      remaining   <= '0;
      lane        <= '0;
      used        <= '0;
      addr        <= '0;
      drain_cnt   <= 1'b0;
      o_clearbuff <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      o_clearbuff <= 1'b0;
      o_done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            remaining   <= i_n_elems;
            lane        <= (i_wofs_init >= WOFS_W'(SRAMC_N)) ? '0 : i_wofs_init;
            addr        <= i_base_addr;
            used        <= '0;
            drain_cnt   <= 1'b0;
            o_clearbuff <= 1'b1;
            state       <= (i_n_elems == '0) ? S_DRAIN : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (issue) begin
            remaining <= remaining - n_take;
            used      <= o_fifo_pop ? '0 : USED_W'(used_next);
            lane      <= lane_wrap ? '0 : WOFS_W'(lane_end);
            if (lane_wrap) addr <= addr + 1'b1;
            if (last_beat) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (i_feeder_en) begin
            if (drain_cnt) begin
              drain_cnt <= 1'b0;
              o_done    <= 1'b1;
              state     <= S_IDLE;
            end else begin
              drain_cnt <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Two enabled stages line the address up with the manager's registered mask.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      addr_s1     <= '0;
      o_sram_addr <= '0;
    end else if (i_feeder_en) begin
      addr_s1     <= addr;
      o_sram_addr <= addr_s1;
    end
  end

`ifdef PSM_WSCHED_PERF_EN
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_stall_cnt <= '0;
    end else if (start_ok) begin
      o_stall_cnt <= '0;
    end else if ((state == S_ISSUE) && !issue && !(&o_stall_cnt)) begin
      o_stall_cnt <= o_stall_cnt + 32'd1;
    end
  end
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_psm_wmask_scheduler.sv
// Randomized bench for psm_wmask_scheduler against an element-level transfer model.
module tb_psm_wmask_scheduler;

  localparam int Y       = 3;
  localparam int SRAMC_N = 2;
  localparam int WOFS_W  = 3;
  localparam int CNT_W   = 16;
  localparam int ADDR_W  = 10;

  typedef struct {
    logic [0:SRAMC_N-1] mask;
    logic               pop;
    logic [ADDR_W-1:0]  addr;
  } beat_t;
  typedef beat_t beat_q_t[$];

  logic               clk = 1'b0;
  logic               rstn;
  logic               start;
  logic [CNT_W-1:0]   n_elems;
  logic [WOFS_W-1:0]  wofs;
  logic [ADDR_W-1:0]  base;
  logic               en;
  logic               empty;
  logic [0:SRAMC_N-1] mask;
  logic               pop;
  logic               clearbuff;
  logic [ADDR_W-1:0]  sram_addr;
  logic               busy;
  logic               done;
`ifdef PSM_WSCHED_PERF_EN
  logic [31:0]        stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  psm_wmask_scheduler #(
    .Y(Y), .SRAMC_N(SRAMC_N), .WOFS_W(WOFS_W), .CNT_W(CNT_W), .ADDR_W(ADDR_W)
  ) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_start      (start),
    .i_n_elems    (n_elems),
    .i_wofs_init  (wofs),
    .i_base_addr  (base),
    .i_feeder_en  (en),
    .i_fifo_empty (empty),
    .o_mask       (mask),
    .o_fifo_pop   (pop),
    .o_clearbuff  (clearbuff),
    .o_sram_addr  (sram_addr),
    .o_busy       (busy),
    .o_done       (done)
`ifdef PSM_WSCHED_PERF_EN
    ,
    .o_stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Walk the transfer element by element: each element lands in one SRAM lane and
  // comes from one FIFO word; a beat is a run sharing both.
  function automatic beat_q_t build_beats(input int n, input int w, input int b);
    beat_q_t q;
    beat_t   cur;
    int      lane0, prev_w, prev_f;
    lane0  = (w >= SRAMC_N) ? 0 : w;
    prev_w = -1;
    prev_f = -1;
    cur.mask = '0;
    cur.pop  = 1'b0;
    cur.addr = '0;
    for (int e = 0; e < n; e++) begin
      int wi, li, fi;
      wi = (lane0 + e) / SRAMC_N;
      li = (lane0 + e) % SRAMC_N;
      fi = e / Y;
      if (wi != prev_w || fi != prev_f) begin
        if (e > 0) q.push_back(cur);
        cur.mask = '0;
        cur.pop  = 1'b0;
        cur.addr = ADDR_W'(b + wi);
      end
      cur.mask[li] = 1'b1;
      if ((e % Y) == Y - 1 || e == n - 1) cur.pop = 1'b1;
      prev_w = wi;
      prev_f = fi;
    end
    if (n > 0) q.push_back(cur);
    return q;
  endfunction

  // Cycle-level expectation derived from the beat queue.
  int                m_phase = 0;   // 0 idle, 1 issuing, 2 draining
  int                m_dcnt  = 0;
  bit                m_clr   = 0;
  bit                m_done  = 0;
  bit                m_p1_v  = 0, m_p2_v = 0;
  logic [ADDR_W-1:0] m_p1_a  = '0, m_p2_a = '0;
  int unsigned       m_stall = 0;
  beat_q_t           mq;

  always @(negedge clk) begin
    bit                 x_issue, n_clr, n_done;
    logic [0:SRAMC_N-1] x_mask;
    logic               x_pop;
    if (!rstn) begin
      check("rst_mask", 64'(mask), 64'd0);
      check("rst_pop", 64'(pop), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_clearbuff", 64'(clearbuff), 64'd0);
      check("rst_sram_addr", 64'(sram_addr), 64'd0);
      m_phase = 0; m_dcnt = 0; m_clr = 0; m_done = 0;
      m_p1_v = 0; m_p2_v = 0; m_p1_a = '0; m_p2_a = '0;
      m_stall = 0;
      mq.delete();
    end else begin
      x_issue = (m_phase == 1) && en && !empty && (mq.size() > 0);
      x_mask  = x_issue ? mq[0].mask : '0;
      x_pop   = x_issue ? mq[0].pop : 1'b0;
      check("mask", 64'(mask), 64'(x_mask));
      check("fifo_pop", 64'(pop), 64'(x_pop));
      check("clearbuff", 64'(clearbuff), 64'(m_clr));
      check("done", 64'(done), 64'(m_done));
      check("busy", 64'(busy), 64'(m_phase != 0));
      if (m_p2_v) check("sram_addr", 64'(sram_addr), 64'(m_p2_a));
`ifdef PSM_WSCHED_PERF_EN
      check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
      n_clr  = 0;
      n_done = 0;
      if (en) begin
        m_p2_v = m_p1_v;
        m_p2_a = m_p1_a;
        m_p1_v = x_issue;
        m_p1_a = x_issue ? mq[0].addr : '0;
      end
      case (m_phase)
        0: if (start) begin
          mq      = build_beats(int'(n_elems), int'(wofs), int'(base));
          n_clr   = 1;
          m_phase = (n_elems == 0) ? 2 : 1;
          m_dcnt  = 0;
          m_stall = 0;
        end
        1: begin
          if (x_issue) begin
            void'(mq.pop_front());
            if (mq.size() == 0) m_phase = 2;
          end else if (m_stall != 32'hFFFF_FFFF) begin
            m_stall++;
          end
        end
        default: if (en) begin
          if (m_dcnt == 1) begin
            n_done  = 1;
            m_phase = 0;
            m_dcnt  = 0;
          end else begin
            m_dcnt = 1;
          end
        end
      endcase
      m_clr  = n_clr;
      m_done = n_done;
    end
  end

  // Pulses start at posedge+1 and returns the cycle (start = 0) where o_done was seen.
  task automatic run_xfer(input int n, input int w, input int b, input bit rnd, output int done_cyc);
    int cyc;
    bit finished;
    start = 1'b1; n_elems = CNT_W'(n); wofs = WOFS_W'(w); base = ADDR_W'(b);
    en = 1'b1; empty = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    done_cyc = -1;
    finished = 0;
    while (!finished && cyc < 400) begin
      if (done) done_cyc = cyc;
      if (!busy) begin
        finished = 1;
      end else begin
        if (rnd) begin
          en      = ($urandom_range(0, 3) != 0);
          empty   = ($urandom_range(0, 3) == 0);
          start   = ($urandom_range(0, 5) == 0);
          n_elems = CNT_W'($urandom);
          wofs    = WOFS_W'($urandom);
          base    = ADDR_W'($urandom);
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!finished) check("xfer_timeout", 64'(cyc), 64'd0);
    start = 1'b0; en = 1'b1; empty = 1'b0;
  endtask

  initial begin
    beat_q_t q;
    int      dc;
    rstn = 1'b0; start = 1'b0; n_elems = '0; wofs = '0; base = '0;
    en = 1'b1; empty = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // Hand-derived beats pin the model.
    q = build_beats(6, 0, 'h10);
    check("pin6_len", 64'(q.size()), 64'd4);
    check("pin6_mask", {q[0].mask, q[1].mask, q[2].mask, q[3].mask}, 64'b11_10_01_11);
    check("pin6_pop", {q[0].pop, q[1].pop, q[2].pop, q[3].pop}, 64'b0101);
    check("pin6_addr", {q[0].addr, q[1].addr, q[2].addr, q[3].addr},
          {10'h10, 10'h11, 10'h11, 10'h12});
    q = build_beats(4, 1, 'h20);
    check("pin4_len", 64'(q.size()), 64'd3);
    check("pin4_mask", {q[0].mask, q[1].mask, q[2].mask}, 64'b01_11_10);
    check("pin4_pop", {q[0].pop, q[1].pop, q[2].pop}, 64'b011);
    check("pin4_addr", {q[0].addr, q[1].addr, q[2].addr}, {10'h20, 10'h21, 10'h22});
    q = build_beats(2, 5, 'h3FF);
    check("pin_wofs_clamp", {q[0].mask, q[0].addr}, {2'b11, 10'h3FF});

    run_xfer(6, 0, 'h10, 0, dc);
    check("done_cyc_n6", 64'(dc), 64'd7);
    run_xfer(0, 1, 'h55, 0, dc);
    check("done_cyc_n0", 64'(dc), 64'd3);
    run_xfer(4, 1, 'h20, 0, dc);
    check("done_cyc_n4", 64'(dc), 64'd6);
    run_xfer(5, 1, 'h3FE, 0, dc);

    for (int t = 0; t < 80; t++) begin
      run_xfer($urandom_range(0, 14), $urandom_range(0, 7), $urandom_range(0, 1023), 1, dc);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // Asynchronous reset while issuing.
    @(posedge clk); #1;
    start = 1'b1; n_elems = 16'd10; wofs = '0; base = 10'h40;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("mid_busy", 64'(busy), 64'd1);
    #1 rstn = 1'b0;
    #1;
    check("async_mask", 64'(mask), 64'd0);
    check("async_pop", 64'(pop), 64'd0);
    check("async_busy", 64'(busy), 64'd0);
    check("async_addr", 64'(sram_addr), 64'd0);
    @(posedge clk); #1 rstn = 1'b1;
    run_xfer(6, 0, 'h10, 0, dc);
    check("done_cyc_after_rst", 64'(dc), 64'd7);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
